// File: rtl/segment_transition_ctl.sv
// rtl/segment_transition_ctl.sv - double-buffered segment swap scheduler for modulation/STM engines
// Latches a swap request and commits it when its transition condition fires; tracks finite loop runs.
module segment_transition_ctl #(
   parameter int IDX_W      = 15,
   parameter int SYS_TIME_W = 56
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  UPDATE,
   input  logic                  REQ_SEGMENT,
   input  logic [15:0]           REP,
   input  logic [7:0]            TRANSITION_MODE,
   input  logic [63:0]           TRANSITION_VALUE,
   input  logic [IDX_W-1:0]      IDX,
   input  logic [SYS_TIME_W-1:0] SYS_TIME,
   input  logic [3:0]            GPIO_IN,
   output logic                  SEGMENT,
   output logic                  STOP,
   output logic [15:0]           LOOP_CNT,
   output logic                  BUSY,
   output logic                  ERR
);

   localparam logic [1:0] S_RUN_INF = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RUN_FIN = 2'd2;
   localparam logic [1:0] S_STOPPED = 2'd3;

   localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
   localparam logic [7:0] MODE_SYS_TIME = 8'h01;
   localparam logic [7:0] MODE_GPIO     = 8'h02;
   localparam logic [7:0] MODE_EXT      = 8'hF0;

   logic [1:0]            state;
   logic [IDX_W-1:0]      idx_d;
   logic [3:0]            gpio_d;
   logic                  req_segment;
   logic [15:0]           req_rep;
   logic [7:0]            req_mode;
   // Holds the deadline for SYS_TIME mode; its low two bits double as the GPIO pin select.
   logic [SYS_TIME_W-1:0] req_value;

   logic                  wrap;
   logic                  mode_valid;
   logic                  gpio_rise;
   logic                  cond;
   logic                  loop_done;
   logic [16:0]           loop_next;
   logic                  unused_value;

   assign unused_value = ^TRANSITION_VALUE[63:SYS_TIME_W];
   assign BUSY         = (state == S_WAIT);

   always_comb begin
      wrap       = (IDX < idx_d);
      gpio_rise  = GPIO_IN[req_value[1:0]] & ~gpio_d[req_value[1:0]];
      mode_valid = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
                   (TRANSITION_MODE == MODE_GPIO)     || (TRANSITION_MODE == MODE_EXT);
      case (req_mode)
         MODE_SYS_TIME: cond = (SYS_TIME >= req_value);
         MODE_GPIO:     cond = gpio_rise;
         default:       cond = wrap | STOP;
      endcase
      // 17-bit compare so REP+1 never aliases to zero.
      loop_next = {1'b0, LOOP_CNT} + 17'd1;
      loop_done = (loop_next == ({1'b0, req_rep} + 17'd1));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_RUN_INF;
         idx_d       <= '0;
         gpio_d      <= '0;
         req_segment <= 1'b0;
         req_rep     <= '0;
         req_mode    <= '0;
         req_value   <= '0;
         SEGMENT     <= 1'b0;
         STOP        <= 1'b0;
         LOOP_CNT    <= '0;
         ERR         <= 1'b0;
      end else begin
         idx_d  <= IDX;
         gpio_d <= GPIO_IN;
         ERR    <= 1'b0;
         // A new request always wins over a pending commit in the same cycle.
         if (UPDATE) begin
            if (mode_valid) begin
               state       <= S_WAIT;
               req_segment <= REQ_SEGMENT;
               req_rep     <= REP;
               req_mode    <= TRANSITION_MODE;
               req_value   <= TRANSITION_VALUE[SYS_TIME_W-1:0];
            end else begin
               ERR <= 1'b1;
            end
         end else begin
            case (state)
               S_WAIT: begin
                  if (cond) begin
                     SEGMENT  <= req_segment;
                     LOOP_CNT <= '0;
                     STOP     <= 1'b0;
                     state    <= (req_rep == 16'hFFFF) ? S_RUN_INF : S_RUN_FIN;
                  end
               end
               S_RUN_FIN: begin
                  if (wrap) begin
                     if (loop_done && (req_mode == MODE_EXT)) begin
                        SEGMENT  <= ~SEGMENT;
                        LOOP_CNT <= '0;
                     end else if (loop_done) begin
                        state    <= S_STOPPED;
                        STOP     <= 1'b1;
                        LOOP_CNT <= loop_next[15:0];
                     end else begin
                        LOOP_CNT <= loop_next[15:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// tb/tb_segment_transition_ctl.sv - self-checking bench for segment_transition_ctl
// Vector table, directed corner sequences, then randomized traffic against a behavioural model.
module tb_segment_transition_ctl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        UPDATE = 1'b0;
   logic        REQ_SEGMENT = 1'b0;
   logic [15:0] REP = '0;
   logic [7:0]  TRANSITION_MODE = '0;
   logic [63:0] TRANSITION_VALUE = '0;
   logic [14:0] IDX = '0;
   logic [55:0] SYS_TIME = '0;
   logic [3:0]  GPIO_IN = '0;
   logic        SEGMENT, STOP, BUSY, ERR;
   logic [15:0] LOOP_CNT;

   segment_transition_ctl #(.IDX_W(15), .SYS_TIME_W(56)) dut (
      .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT), .REP(REP),
      .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE), .IDX(IDX),
      .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .SEGMENT(SEGMENT), .STOP(STOP),
      .LOOP_CNT(LOOP_CNT), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: a pending request plus a description of the current run.
   bit          m_seg, m_stop, m_busy, m_err;
   logic [15:0] m_loop;
   bit          p_seg;
   logic [15:0] p_rep;
   logic [7:0]  p_mode;
   logic [63:0] p_val;
   bit          run_finite, run_pingpong;
   int          run_target;
   int          last_idx;
   logic [3:0]  last_gpio;

   function automatic bit mode_known(logic [7:0] m);
      return m == 8'h00 || m == 8'h01 || m == 8'h02 || m == 8'hF0;
   endfunction

   task automatic model_reset();
      m_seg = 0; m_stop = 0; m_busy = 0; m_err = 0; m_loop = 0;
      p_seg = 0; p_rep = 0; p_mode = 0; p_val = 0;
      run_finite = 0; run_pingpong = 0; run_target = 0;
      last_idx = 0; last_gpio = 0;
   endtask

   task automatic model_edge();
      bit wrap, fire;
      int pin;
      wrap  = int'(IDX) < last_idx;
      m_err = 0;
      if (UPDATE) begin
         if (mode_known(TRANSITION_MODE)) begin
            m_busy = 1; p_seg = REQ_SEGMENT; p_rep = REP;
            p_mode = TRANSITION_MODE; p_val = TRANSITION_VALUE;
         end else m_err = 1;
      end else if (m_busy) begin
         pin = int'(p_val[1:0]);
         if (p_mode == 8'h01)      fire = SYS_TIME >= p_val[55:0];
         else if (p_mode == 8'h02) fire = GPIO_IN[pin] && !last_gpio[pin];
         else                      fire = wrap || m_stop;
         if (fire) begin
            m_seg = p_seg; m_loop = 0; m_stop = 0; m_busy = 0;
            run_finite   = (p_rep != 16'hFFFF);
            run_pingpong = (p_mode == 8'hF0);
            run_target   = int'(p_rep) + 1;
         end
      end else if (run_finite && !m_stop && wrap) begin
         if (int'(m_loop) + 1 == run_target) begin
            if (run_pingpong) begin m_seg = !m_seg; m_loop = 0; end
            else begin m_stop = 1; m_loop = 16'(run_target); end
         end else m_loop = m_loop + 16'd1;
      end
      last_idx  = int'(IDX);
      last_gpio = GPIO_IN;
   endtask

   function automatic logic [19:0] pack(bit s, bit st, logic [15:0] l, bit b, bit e);
      return {s, st, l, b, e};
   endfunction

   task automatic check(string name, logic [19:0] exp);
      logic [19:0] act;
      act = {SEGMENT, STOP, LOOP_CNT, BUSY, ERR};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got seg/stop/loop/busy/err=%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                  name, act[19], act[18], act[17:2], act[1], act[0],
                  exp[19], exp[18], exp[17:2], exp[1], exp[0]);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      UPDATE = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      UPDATE = 0; IDX = 0; GPIO_IN = 0; SYS_TIME = 0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
   endtask

   task automatic req(bit s, logic [15:0] r, logic [7:0] m, logic [63:0] v);
      UPDATE = 1; REQ_SEGMENT = s; REP = r; TRANSITION_MODE = m; TRANSITION_VALUE = v;
   endtask

   typedef struct {
      bit          upd;
      bit          rseg;
      logic [15:0] rep;
      logic [7:0]  mode;
      logic [14:0] idx;
      logic [19:0] exp;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(bit u, bit s, logic [15:0] r, logic [7:0] m, logic [14:0] i,
                               bit es, bit est, logic [15:0] el, bit eb, bit ee);
      vec_t v;
      v.upd = u; v.rseg = s; v.rep = r; v.mode = m; v.idx = i;
      v.exp = pack(es, est, el, eb, ee);
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(1, 1, 16'hFFFF, 8'h00, 5, 0, 0, 0, 1, 0);
      tbl[1]  = mk(0, 0, 0,        8'h00, 6, 0, 0, 0, 1, 0);
      tbl[2]  = mk(0, 0, 0,        8'h00, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0,        8'h00, 1, 1, 0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 16'd1,    8'h00, 2, 1, 0, 0, 1, 0);
      tbl[5]  = mk(0, 0, 0,        8'h00, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0,        8'h00, 3, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0,        8'h00, 0, 0, 0, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0,        8'h00, 1, 0, 0, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0,        8'h00, 0, 0, 1, 2, 0, 0);
      tbl[10] = mk(0, 0, 0,        8'h00, 4, 0, 1, 2, 0, 0);
      tbl[11] = mk(1, 1, 16'hFFFF, 8'h00, 5, 0, 1, 2, 1, 0);
      tbl[12] = mk(0, 0, 0,        8'h00, 6, 1, 0, 0, 0, 0);
      tbl[13] = mk(1, 0, 16'd3,    8'h07, 7, 1, 0, 0, 0, 1);
      tbl[14] = mk(0, 0, 0,        8'h00, 8, 1, 0, 0, 0, 0);

      do_reset();
      check("reset_state", pack(0, 0, 0, 0, 0));

      for (int i = 0; i < 15; i++) begin
         UPDATE = tbl[i].upd; REQ_SEGMENT = tbl[i].rseg; REP = tbl[i].rep;
         TRANSITION_MODE = tbl[i].mode; TRANSITION_VALUE = '0; IDX = tbl[i].idx;
         tick();
         check($sformatf("table_%0d", i), tbl[i].exp);
      end

      // Asynchronous reset lands between edges and must clear outputs immediately.
      #2 RST = 1'b1;
      #1 check("async_rst", pack(0, 0, 0, 0, 0));
      @(negedge CLK);
      RST = 1'b0;
      model_reset();

      // SYS_TIME deadline, then a deadline already in the past.
      SYS_TIME = 998; req(1, 16'hFFFF, 8'h01, 64'd1000); tick();
      check("systime_wait", pack(0, 0, 0, 1, 0));
      SYS_TIME = 999; tick();
      check("systime_999", pack(0, 0, 0, 1, 0));
      SYS_TIME = 1000; tick();
      check("systime_commit", pack(1, 0, 0, 0, 0));
      SYS_TIME = 100; req(0, 16'hFFFF, 8'h01, 64'd5); tick();
      check("systime_past_wait", pack(1, 0, 0, 1, 0));
      SYS_TIME = 101; tick();
      check("systime_past_commit", pack(0, 0, 0, 0, 0));

      // GPIO rising edge on the selected pin only.
      do_reset();
      GPIO_IN = 4'b0100; tick();
      req(1, 16'hFFFF, 8'h02, 64'd2); tick();
      check("gpio_wait", pack(0, 0, 0, 1, 0));
      tick();
      check("gpio_held_high", pack(0, 0, 0, 1, 0));
      GPIO_IN = 4'b0110; tick();
      check("gpio_other_pin", pack(0, 0, 0, 1, 0));
      GPIO_IN = 4'b0010; tick();
      GPIO_IN = 4'b0110; tick();
      check("gpio_commit", pack(1, 0, 0, 0, 0));

      // EXT ping-pong with REP=0, then a request overridden while waiting.
      do_reset();
      IDX = 1; req(1, 16'd0, 8'hF0, 64'd0); tick();
      check("ext_wait", pack(0, 0, 0, 1, 0));
      IDX = 0; tick();
      check("ext_commit", pack(1, 0, 0, 0, 0));
      IDX = 1; tick();
      IDX = 0; tick();
      check("ext_toggle_0", pack(0, 0, 0, 0, 0));
      IDX = 1; tick();
      IDX = 0; tick();
      check("ext_toggle_1", pack(1, 0, 0, 0, 0));
      IDX = 1; req(1, 16'hFFFF, 8'h00, 64'd0); tick();
      check("override_first", pack(1, 0, 0, 1, 0));
      IDX = 0; req(0, 16'hFFFF, 8'h00, 64'd0); tick();
      check("override_on_wrap", pack(1, 0, 0, 1, 0));
      IDX = 1; tick();
      IDX = 0; tick();
      check("override_commit", pack(0, 0, 0, 0, 0));

      // Randomized traffic against the model.
      do_reset();
      SYS_TIME = 56'd1000;
      for (int c = 0; c < 4000; c++) begin
         int sel, off;
         logic [7:0]  mode;
         logic [15:0] rep;
         if ($urandom_range(0, 5) == 0) IDX = 15'($urandom_range(0, 2));
         else if (IDX != 15'h7FFF) IDX = IDX + 15'd1;
         SYS_TIME = SYS_TIME + 56'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) GPIO_IN[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 11) == 0) begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: mode = 8'h00;
               1: mode = 8'h01;
               2: mode = 8'h02;
               3: mode = 8'hF0;
               4: mode = 8'h07;
               default: mode = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
               0: rep = 16'd0;
               1: rep = 16'd1;
               2: rep = 16'd2;
               3: rep = 16'd3;
               default: rep = 16'hFFFF;
            endcase
            off = $urandom_range(0, 60) - 20;
            if (mode == 8'h01)
               req(1'($urandom), rep, mode, {8'($urandom), SYS_TIME + 56'(off)});
            else
               req(1'($urandom), rep, mode, {32'($urandom), 32'($urandom)});
         end
         tick();
         check("random", pack(m_seg, m_stop, m_loop, m_busy, m_err));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
